cnt_period_ctrl: RTL

- Control stage that sits directly in front of a 16-bit down counter with CAI/CAO cascade and parallel load, and consumes that counter's CAO terminal-count output.
- Drives the counter's LD, D[15:0], EN and CAI to give programmable one-shot or periodic intervals in units of TICK.
- Double-buffers the period through a valid/ready handshake.
- Reports each terminal count as an interrupt with ack, a sticky overrun flag and a saturating event count.

---
 rtl/cnt_pkg.sv | 22 ++
 rtl/cnt_period_shadow.sv | 51 +++++
 rtl/cnt_period_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt_pkg
// Brief    : Shared types and constants for the period controller.
// Revision : 1.0
// ============================================================================
package cnt_pkg;

   localparam int W_DEFAULT = 16;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/cnt_period_shadow.sv
`default_nettype none
// ============================================================================
// Module   : cnt_period_shadow
// Brief    : Double-buffered period register with valid/ready write port.
// Revision : 1.0
// ============================================================================
module cnt_period_shadow
   import cnt_pkg::*;
#(
   parameter int           W          = W_DEFAULT,
   parameter logic [W-1:0] RST_PERIOD = W'(1000)
) (
   input  logic         CLK,
   input  logic         RSTN,
   input  logic         i_pv,
   input  logic [W-1:0] i_period,
   output logic         o_pr,
   input  logic         i_reload,
   output logic [W-1:0] o_shadow,
   output logic [W-1:0] o_reload_val
);

   logic         r_pending;
   logic [W-1:0] r_pend_val;
   logic [W-1:0] r_shadow;

   // A write accepted on the same edge as a reload stays pending for the next one.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_pending  <= 1'b0;
         r_pend_val <= '0;
         r_shadow   <= RST_PERIOD;
      end else begin
         if (i_reload) begin
            r_shadow <= o_reload_val;
         end
         if (i_pv && o_pr) begin
            r_pend_val <= i_period;
            r_pending  <= 1'b1;
         end else if (i_reload) begin
            r_pending  <= 1'b0;
         end
      end
   end

   assign o_pr         = !r_pending;
   assign o_shadow     = r_shadow;
   assign o_reload_val = r_pending ? r_pend_val : r_shadow;

endmodule : cnt_period_shadow
`default_nettype wire

// File: rtl/cnt_period_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cnt_period_ctrl
// Brief    : One-shot / periodic interval controller for a CAI/CAO down counter.
// Revision : 1.0
// ============================================================================
module cnt_period_ctrl
   import cnt_pkg::*;
#(
   parameter int           W          = W_DEFAULT,
   parameter int           CW         = 8,
   parameter logic [W-1:0] RST_PERIOD = W'(1000)
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          TICK,
   input  logic          START,
   input  logic          STOP,
   input  logic          MODE,
   input  logic          PV,
   input  logic [W-1:0]  PERIOD,
   output logic          PR,
   input  logic          CAO,
   output logic          LD,
   output logic [W-1:0]  DOUT,
   output logic          EN,
   output logic          CAI,
   output logic          BUSY,
   output logic          IRQ,
   input  logic          IACK,
   output logic          OVR,
   output logic [CW-1:0] TC_CNT,
   input  logic          CLR_CNT
);

   localparam logic [CW-1:0] c_TC_MAX = '1;
   localparam logic [CW-1:0] c_TC_ONE = CW'(1);
   localparam logic [W-1:0]  c_ONE    = W'(1);

   state_t        r_state;
   state_t        w_state_next;
   logic          r_mode;
   logic          r_irq;
   logic          r_ovr;
   logic [CW-1:0] r_tc;

   logic          w_start_ok;
   logic          w_term;
   logic          w_reload;
   logic [W-1:0]  w_shadow;
   logic [W-1:0]  w_reload_val;

   // START is honoured from IDLE and as a restart from RUN; STOP always wins.
   assign w_start_ok = START && !STOP && ((r_state == IDLE) || (r_state == RUN));
   assign w_term     = (r_state == RUN) && CAO && !STOP;
   assign w_reload   = w_start_ok || (w_term && (r_mode == MODE_PERIODIC));

   cnt_period_shadow #(
      .W          (W),
      .RST_PERIOD (RST_PERIOD)
   ) u_shadow (
      .CLK          (CLK),
      .RSTN         (RSTN),
      .i_pv         (PV),
      .i_period     (PERIOD),
      .o_pr         (PR),
      .i_reload     (w_reload),
      .o_shadow     (w_shadow),
      .o_reload_val (w_reload_val)
   );

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_state <= IDLE;
         r_mode  <= MODE_ONESHOT;
      end else begin
         r_state <= w_state_next;
         if (w_start_ok) begin
            r_mode <= MODE;
         end
      end
   end

   // EN/CAI stay off the CAO path so the counter loop has no combinational cycle.
   assign EN   = (r_state == RUN);
   assign CAI  = (r_state == RUN) && TICK;
   assign BUSY = (r_state == LOAD) || (r_state == RUN);

   always_comb begin
      w_state_next = r_state;
      LD           = 1'b0;
      DOUT         = '0;
      case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_state_next = LOAD;
            end
         end
         LOAD: begin
            LD           = 1'b1;
            DOUT         = w_shadow - c_ONE;
            w_state_next = STOP ? IDLE : RUN;
         end
         RUN: begin
            if (w_term) begin
               LD   = 1'b1;
               DOUT = (r_mode == MODE_PERIODIC) ? (w_reload_val - c_ONE) : '0;
            end
            if (STOP) begin
               w_state_next = IDLE;
            end else if (START) begin
               w_state_next = LOAD;
            end else if (CAO && (r_mode == MODE_ONESHOT)) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_irq <= 1'b0;
         r_ovr <= 1'b0;
         r_tc  <= '0;
      end else begin
         if (w_term) begin
            r_irq <= 1'b1;
         end else if (IACK) begin
            r_irq <= 1'b0;
         end
         if (CLR_CNT) begin
            r_ovr <= 1'b0;
            r_tc  <= w_term ? c_TC_ONE : '0;
         end else begin
            if (w_term && r_irq && !IACK) begin
               r_ovr <= 1'b1;
            end
            if (w_term && (r_tc != c_TC_MAX)) begin
               r_tc <= r_tc + c_TC_ONE;
            end
         end
      end
   end

   assign IRQ    = r_irq;
   assign OVR    = r_ovr;
   assign TC_CNT = r_tc;

endmodule : cnt_period_ctrl
`default_nettype wire
